mc_a_xfer: RTL
==============

Name: mc_a_xfer

Overview:
Source stage of the memory-transfer path. It loads DEPTH words into local memory A, then, on Start, streams them in order into downstream memory B. It drives B's IncB/WEB/DataInB controls directly, using B's encoding:
- WEB=1, IncB=0: write the word and advance B's address.
- WEB=0, IncB=1: hold B's address.
- WEB=IncB: clear B's address.
A Stall input lets the consumer side pause the stream without losing B's address.

Parameters:
WIDTH, 8, data word width (must match B's DataInB).
DEPTH, 4, words per transfer; power of 2, at least 2; must equal B's depth.
AW, 2, address width; derived as log2(DEPTH), not overridden.

Ports:
clock  in  1  rising-edge clock
Reset  in  1  synchronous, active-low reset
DataInA  in  WIDTH  load data for memory A
WEA  in  1  load strobe; writes DataInA at AddrA and advances AddrA
Start  in  1  begin transfer; accepted only in IDLE with Full=1
Stall  in  1  pause transfer this cycle
IncB  out  1  to B: hold-address request
WEB  out  1  to B: write-and-advance request
DataInB  out  WIDTH  to B: word being written
AddrA  out  AW  current memory-A pointer
Full  out  1  DEPTH words loaded, ready to transfer
Busy  out  1  transfer in progress
Done  out  1  one-cycle pulse, transfer complete

Behaviour:
- Reset (Reset=0 at posedge):
  - state=IDLE, AddrA=0, Full=0, Done=0.
  - Outputs: IncB=0, WEB=0 (B clears its address), DataInB=0, Busy=0.
  - Memory A contents are not cleared.
  - Reset mid-transfer aborts immediately; there is no partial-completion Done.
- States: IDLE, XFER, DONE. State and AddrA are registered. IncB, WEB, DataInB and Busy are combinational decodes of the registered state, AddrA and Stall, so B sees them in the same cycle.
- IDLE:
  - IncB=0, WEB=0, DataInB=0, Busy=0.
  - WEA=1 and Full=0: MemA[AddrA] <= DataInA; AddrA++.
  - The write at AddrA=DEPTH-1 wraps AddrA to 0 and sets Full=1.
  - WEA while Full=1 is ignored: no write, no pointer move.
  - Start=1 and Full=1: go to XFER, AddrA stays 0. Start takes priority over a same-cycle WEA.
  - Start with Full=0 is ignored, including the cycle of the final load write, since Full is not yet visible.
- XFER (Busy=1, DataInB=MemA[AddrA], combinational read):
  - Stall=0: WEB=1, IncB=0; AddrA++ at posedge. B writes DataInB and advances.
  - Stall=1: WEB=0, IncB=1; AddrA holds. B's address holds and there is no write. Stall never makes WEB=IncB, so B's address is never cleared mid-stream.
  - After the non-stalled cycle with AddrA=DEPTH-1: AddrA wraps to 0, go to DONE.
  - Transfer length is DEPTH plus the number of stalled cycles. Start and WEA are ignored.
- DONE (one cycle):
  - Done=1, Busy=0, WEB=0, IncB=1, DataInB=0.
  - Full cleared; next state is IDLE.
  - Stall is ignored in DONE.
- Back-to-back transfers require a fresh load of DEPTH words.
- Arithmetic: AddrA is unsigned AW-bit and wraps naturally. There is no counter separate from AddrA; the terminal condition is AddrA==DEPTH-1 with a non-stalled cycle.

Decomposition:
- Shared package mc_pkg:
  - state enum {IDLE, XFER, DONE}.
  - B command constants: CMD_CLR (IncB=0, WEB=0), CMD_WRINC (IncB=0, WEB=1), CMD_HOLD (IncB=1, WEB=0).
  - Default WIDTH and DEPTH, also used by B.
- One sub-module, mc_a_ram: DEPTH×WIDTH array, synchronous write, asynchronous read.
- The FSM, AddrA pointer and output decode live in mc_a_xfer.

Test Plan:
- Load 0x11, 0x22, 0x33, 0x44 with WEA in consecutive cycles -> Full=1 after the 4th edge, AddrA=0; a 5th WEA of 0x55 is ignored, AddrA stays 0.
- Start with Full=1, Stall=0 -> 4 cycles of WEB=1/IncB=0 with DataInB=0x11, 0x22, 0x33, 0x44; then one DONE cycle (Done=1, IncB=1); B contains 11/22/33/44; Full=0.
- Same transfer with Stall=1 on the 2nd and 3rd XFER cycles -> WEB=0/IncB=1 on those cycles, DataInB held at 0x22; B order unchanged; Busy high for 6 cycles.
- Start after only 3 loads -> stays in IDLE, IncB=WEB=0; Start on the cycle of the 4th WEA -> ignored, and accepted one cycle later.
- Reset=0 during the 3rd XFER cycle -> next cycle IDLE, AddrA=0, Full=0, Done never pulses, IncB=WEB=0.
- Reset=0 for one cycle, then reload 4 words and run Start -> identical result to the no-stall case, confirming no state leaks across reset.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and constants for the A->B memory-transfer path.
// B command encoding is {IncB, WEB}; CMD_CLR also serves as the idle/reset command.
package mc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] CMD_CLR   = 2'b00;
   localparam logic [1:0] CMD_WRINC = 2'b01;
   localparam logic [1:0] CMD_HOLD  = 2'b10;

   localparam int MC_WIDTH = 8;
   localparam int MC_DEPTH = 4;

endpackage

// File: rtl/mc_a_ram.sv
// Local memory A: DEPTH x WIDTH, synchronous write, asynchronous read.
// Single shared address; contents are intentionally not reset.
module mc_a_ram
   import mc_pkg::*;
#(
   parameter int WIDTH = MC_WIDTH,
   parameter int DEPTH = MC_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             i_we,
   input  logic [AW-1:0]    i_addr,
   input  logic [WIDTH-1:0] i_wdat,
   output logic [WIDTH-1:0] o_rdat
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clock) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdat;
      end
   end

   assign o_rdat = r_mem[i_addr];

endmodule

// File: rtl/mc_a_xfer.sv
// Loads DEPTH words into memory A, then on Start streams them into B; B controls are same-cycle decodes.
// Stall holds B's address (never clears it); one-cycle Done after the last non-stalled word.
module mc_a_xfer
   import mc_pkg::*;
#(
   parameter int WIDTH = MC_WIDTH,
   parameter int DEPTH = MC_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] DataInA,
   input  logic             WEA,
   input  logic             Start,
   input  logic             Stall,
   output logic             IncB,
   output logic             WEB,
   output logic [WIDTH-1:0] DataInB,
   output logic [AW-1:0]    AddrA,
   output logic             Full,
   output logic             Busy,
   output logic             Done
);

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   state_t           r_state;
   logic [AW-1:0]    r_addr;
   logic             r_full;
   logic             w_we;
   logic [WIDTH-1:0] w_rdat;
   logic [1:0]       w_cmd;
   logic [WIDTH-1:0] w_datb;
   logic             w_busy;

   // Start is only accepted when Full, so a load write can never coincide with it.
   assign w_we = (r_state == IDLE) && WEA && !r_full;

   mc_a_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clock  (clock),
      .i_we   (w_we),
      .i_addr (r_addr),
      .i_wdat (DataInA),
      .o_rdat (w_rdat)
   );

   always_ff @(posedge clock) begin
      if (!Reset) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_full  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (Start && r_full) begin
                  r_state <= XFER;
               end else if (w_we) begin
                  r_addr <= r_addr + AW'(1);
                  if (r_addr == LAST) begin
                     r_full <= 1'b1;
                  end
               end
            end
            XFER: begin
               if (!Stall) begin
                  r_addr <= r_addr + AW'(1);
                  if (r_addr == LAST) begin
                     r_state <= DONE;
                  end
               end
            end
            DONE: begin
               r_full  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      w_cmd  = CMD_CLR;
      w_datb = '0;
      w_busy = 1'b0;
      case (r_state)
         XFER: begin
            w_busy = 1'b1;
            w_datb = w_rdat;
            w_cmd  = Stall ? CMD_HOLD : CMD_WRINC;
         end
         DONE:    w_cmd = CMD_HOLD;
         default: w_cmd = CMD_CLR;
      endcase
   end

   assign {IncB, WEB} = w_cmd;
   assign DataInB     = w_datb;
   assign Busy        = w_busy;
   assign AddrA       = r_addr;
   assign Full        = r_full;
   assign Done        = (r_state == DONE);

endmodule
